// File: rtl/mem_arbiter.sv
// Shares one memory port between a CSR writer and two burst readers (write first, then round-robin A/B).
// Grant and memory strobes are registered; read beats return one cycle after their address; requests are held until granted.
module mem_arbiter #(
    parameter int MAX_LEN = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_req,
    input  logic [15:0]  wr_addr,
    input  logic [7:0]   wr_data,
    output logic         wr_ack,
    input  logic         rda_req,
    input  logic [15:0]  rda_addr,
    input  logic [7:0]   rda_len,
    output logic         rda_gnt,
    input  logic         rdb_req,
    input  logic [15:0]  rdb_addr,
    input  logic [7:0]   rdb_len,
    output logic         rdb_gnt,
    output logic         rd_valid_a,
    output logic         rd_valid_b,
    output logic         rd_last,
    output logic [127:0] rd_data,
    output logic         mem_wen,
    output logic [15:0]  mem_writePtr,
    output logic [15:0]  mem_readPtr,
    output logic [7:0]   mem_inData,
    input  logic [127:0] mem_outData
);

    typedef enum logic [1:0] {IDLE, WRITE, BURST_A, BURST_B} state_t;

    localparam logic [7:0] MAX_LEN_W = 8'(MAX_LEN);

    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  len_q, len_d;
    logic [15:0] wp_q, wp_d;
    logic [7:0]  wd_q, wd_d;
    logic [15:0] rp_q, rp_d;
    logic        val_a_q, val_a_d;
    logic        val_b_q, val_b_d;
    logic        last_q, last_d;
    logic        in_burst;
    logic        final_issue;
    logic        pick_a;

    function automatic logic [7:0] eff_len(input logic [7:0] l);
        if (l == 8'd0)
            return 8'd1;
        else if (l > MAX_LEN_W)
            return MAX_LEN_W;
        else
            return l;
    endfunction

    assign in_burst    = (state_q == BURST_A) || (state_q == BURST_B);
    assign final_issue = in_burst && (cnt_q == len_q - 8'd1);
    // A wins a tie unless it was the most recent reader.
    assign pick_a      = rda_req && (!rdb_req || last_b_q);

    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        wp_d     = wp_q;
        wd_d     = wd_q;
        rp_d     = rp_q;
        val_a_d  = (state_q == BURST_A);
        val_b_d  = (state_q == BURST_B);
        last_d   = final_issue;

        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    state_d = WRITE;
                    wp_d    = wr_addr;
                    wd_d    = wr_data;
                end else if (pick_a) begin
                    state_d  = BURST_A;
                    last_b_d = 1'b0;
                    rp_d     = rda_addr;
                    len_d    = eff_len(rda_len);
                    cnt_d    = 8'd0;
                end else if (rdb_req) begin
                    state_d  = BURST_B;
                    last_b_d = 1'b1;
                    rp_d     = rdb_addr;
                    len_d    = eff_len(rdb_len);
                    cnt_d    = 8'd0;
                end
            end
            WRITE: state_d = IDLE;
            BURST_A, BURST_B: begin
                if (final_issue) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    rp_d  = rp_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            cnt_q    <= 8'd0;
            len_q    <= 8'd0;
            wp_q     <= 16'd0;
            wd_q     <= 8'd0;
            rp_q     <= 16'd0;
            val_a_q  <= 1'b0;
            val_b_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            wp_q     <= wp_d;
            wd_q     <= wd_d;
            rp_q     <= rp_d;
            val_a_q  <= val_a_d;
            val_b_q  <= val_b_d;
            last_q   <= last_d;
        end
    end

    assign wr_ack       = (state_q == WRITE);
    assign mem_wen      = (state_q == WRITE);
    assign rda_gnt      = (state_q == BURST_A);
    assign rdb_gnt      = (state_q == BURST_B);
    assign mem_writePtr = wp_q;
    assign mem_inData   = wd_q;
    assign mem_readPtr  = rp_q;
    assign rd_valid_a   = val_a_q;
    assign rd_valid_b   = val_b_q;
    assign rd_last      = last_q;
    // The memory already registers its output, so the beat passes straight through.
    assign rd_data      = (val_a_q || val_b_q) ? mem_outData : 128'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level schedule model plus directed scenarios with literal expectations.
module tb_mem_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         wr_req = 1'b0;
    logic [15:0]  wr_addr = 16'd0;
    logic [7:0]   wr_data = 8'd0;
    logic         wr_ack;
    logic         rda_req = 1'b0;
    logic [15:0]  rda_addr = 16'd0;
    logic [7:0]   rda_len = 8'd0;
    logic         rda_gnt;
    logic         rdb_req = 1'b0;
    logic [15:0]  rdb_addr = 16'd0;
    logic [7:0]   rdb_len = 8'd0;
    logic         rdb_gnt;
    logic         rd_valid_a;
    logic         rd_valid_b;
    logic         rd_last;
    logic [127:0] rd_data;
    logic         mem_wen;
    logic [15:0]  mem_writePtr;
    logic [15:0]  mem_readPtr;
    logic [7:0]   mem_inData;
    logic [127:0] mem_outData = 128'd0;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en = 1'b0;
    bit auto_drop = 1'b1;

    mem_arbiter #(.MAX_LEN(255)) dut (
        .clk(clk), .reset(reset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rda_req(rda_req), .rda_addr(rda_addr), .rda_len(rda_len), .rda_gnt(rda_gnt),
        .rdb_req(rdb_req), .rdb_addr(rdb_addr), .rdb_len(rdb_len), .rdb_gnt(rdb_gnt),
        .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b), .rd_last(rd_last), .rd_data(rd_data),
        .mem_wen(mem_wen), .mem_writePtr(mem_writePtr), .mem_readPtr(mem_readPtr),
        .mem_inData(mem_inData), .mem_outData(mem_outData)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat(input logic [15:0] a);
        return {4{a, ~a}};
    endfunction

    // Memory read port: one-cycle registered lookup of a per-address pattern.
    always @(posedge clk) mem_outData <= pat(mem_readPtr);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic         wr_ack;
        logic         wen;
        logic         gnt_a;
        logic         gnt_b;
        logic         val_a;
        logic         val_b;
        logic         last;
        logic [15:0]  wp;
        logic [7:0]   wd;
        logic [15:0]  rp;
        logic [127:0] data;
    } exp_t;

    exp_t        q[$];
    exp_t        cur = '0;
    logic [15:0] h_wp = 16'd0;
    logic [7:0]  h_wd = 8'd0;
    logic [15:0] h_rp = 16'd0;
    bit          m_last_b = 1'b1;

    function automatic exp_t idle_entry();
        exp_t e;
        e = '0;
        e.wp = h_wp;
        e.wd = h_wd;
        e.rp = h_rp;
        return e;
    endfunction

    task automatic push_write(input logic [15:0] a, input logic [7:0] d);
        exp_t e;
        h_wp = a;
        h_wd = d;
        e = idle_entry();
        e.wr_ack = 1'b1;
        e.wen = 1'b1;
        q.push_back(e);
        q.push_back(idle_entry());
    endtask

    // A burst of L issues, then the mandatory idle cycle which carries the last beat.
    task automatic push_burst(input bit is_b, input logic [15:0] base, input logic [7:0] len_in);
        exp_t e;
        int L;
        L = (len_in == 8'd0) ? 1 : int'(len_in);
        for (int i = 0; i < L; i++) begin
            e = idle_entry();
            e.gnt_a = !is_b;
            e.gnt_b = is_b;
            e.rp = base + 16'(i);
            if (i > 0) begin
                e.val_a = !is_b;
                e.val_b = is_b;
                e.data = pat(base + 16'(i - 1));
            end
            q.push_back(e);
        end
        h_rp = base + 16'(L - 1);
        e = idle_entry();
        e.val_a = !is_b;
        e.val_b = is_b;
        e.last = 1'b1;
        e.data = pat(h_rp);
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            h_wp = 16'd0;
            h_wd = 8'd0;
            h_rp = 16'd0;
            m_last_b = 1'b1;
            cur = '0;
        end else begin
            if (q.size() == 0) begin
                if (wr_req) begin
                    push_write(wr_addr, wr_data);
                end else if (rda_req && (!rdb_req || m_last_b)) begin
                    push_burst(1'b0, rda_addr, rda_len);
                    m_last_b = 1'b0;
                end else if (rdb_req) begin
                    push_burst(1'b1, rdb_addr, rdb_len);
                    m_last_b = 1'b1;
                end
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = idle_entry();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_wr_ack", 128'(wr_ack), 128'(cur.wr_ack));
            chk("cmp_mem_wen", 128'(mem_wen), 128'(cur.wen));
            chk("cmp_rda_gnt", 128'(rda_gnt), 128'(cur.gnt_a));
            chk("cmp_rdb_gnt", 128'(rdb_gnt), 128'(cur.gnt_b));
            chk("cmp_rd_valid_a", 128'(rd_valid_a), 128'(cur.val_a));
            chk("cmp_rd_valid_b", 128'(rd_valid_b), 128'(cur.val_b));
            chk("cmp_rd_last", 128'(rd_last), 128'(cur.last));
            chk("cmp_writePtr", 128'(mem_writePtr), 128'(cur.wp));
            chk("cmp_inData", 128'(mem_inData), 128'(cur.wd));
            chk("cmp_readPtr", 128'(mem_readPtr), 128'(cur.rp));
            chk("cmp_rd_data", rd_data, cur.data);
        end
    end

    always @(posedge clk) begin
        #1;
        if (auto_drop) begin
            if (wr_ack) wr_req = 1'b0;
            if (rda_gnt) rda_req = 1'b0;
            if (rdb_gnt) rdb_req = 1'b0;
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0: return wr_ack;
            1: return rda_gnt;
            default: return rdb_gnt;
        endcase
    endfunction

    task automatic wait_for(input int w, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sel(w) && n < 50);
        chk(name, 128'(sel(w)), 128'd1);
    endtask

    task automatic step_in();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_ack"}, 128'(wr_ack), 128'd0);
        chk({tag, "_wen"}, 128'(mem_wen), 128'd0);
        chk({tag, "_gnt"}, 128'({rda_gnt, rdb_gnt}), 128'd0);
        chk({tag, "_valid"}, 128'({rd_valid_a, rd_valid_b, rd_last}), 128'd0);
        chk({tag, "_ptrs"}, 128'({mem_writePtr, mem_readPtr, mem_inData}), 128'd0);
        chk({tag, "_rd_data"}, rd_data, 128'd0);
    endtask

    logic [15:0] wrap_exp [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    logic [7:0]  alt_exp [4] = '{"A", "B", "A", "B"};
    logic [7:0]  seq [4];

    initial begin
        int t_w, t_a, t_b, nfound;
        logic pa, pb;

        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Single write
        step_in();
        wr_addr = 16'h0010; wr_data = 8'hA5; wr_req = 1'b1;
        wait_for(0, "wr_ack_seen");
        chk("wr_wen", 128'(mem_wen), 128'd1);
        chk("wr_ptr", 128'(mem_writePtr), 128'h0010);
        chk("wr_data", 128'(mem_inData), 128'hA5);
        @(negedge clk);
        chk("wr_ack_one_cycle", 128'(wr_ack), 128'd0);
        chk("wr_ptr_hold", 128'(mem_writePtr), 128'h0010);

        // Single burst on A
        step_in();
        rda_addr = 16'h0100; rda_len = 8'd4; rda_req = 1'b1;
        wait_for(1, "burst_a_gnt");
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("burst_ptr%0d", i), 128'(mem_readPtr), 128'(16'h0100 + 16'(i)));
            chk($sformatf("burst_gnt%0d", i), 128'(rda_gnt), 128'd1);
            chk($sformatf("burst_val%0d", i), 128'(rd_valid_a), 128'(i > 0));
        end
        @(negedge clk);
        chk("burst_end_gnt", 128'(rda_gnt), 128'd0);
        chk("burst_last_beat", 128'({rd_valid_a, rd_last}), 128'b11);
        chk("burst_last_data", rd_data, pat(16'h0103));
        @(negedge clk);
        chk("burst_after", 128'(rd_valid_a), 128'd0);

        // Contention from a fresh reset: write, then A, then B
        step_in();
        reset = 1'b1;
        step_in();
        reset = 1'b0;
        wr_addr = 16'h0020; wr_data = 8'h3C; wr_req = 1'b1;
        rda_addr = 16'h0200; rda_len = 8'd2; rda_req = 1'b1;
        rdb_addr = 16'h0300; rdb_len = 8'd3; rdb_req = 1'b1;
        t_w = -1; t_a = -1; t_b = -1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (wr_ack && t_w < 0) t_w = c;
            if (rda_gnt && t_a < 0) t_a = c;
            if (rdb_gnt && t_b < 0) t_b = c;
        end
        chk("order_w_to_a", 128'(t_a - t_w), 128'd2);
        chk("order_a_to_b", 128'(t_b - t_a), 128'd3);

        // Both readers held continuously: grants alternate
        auto_drop = 1'b0;
        step_in();
        rda_addr = 16'h0700; rda_len = 8'd2; rda_req = 1'b1;
        rdb_addr = 16'h0800; rdb_len = 8'd3; rdb_req = 1'b1;
        pa = rda_gnt; pb = rdb_gnt; nfound = 0;
        for (int c = 0; c < 40 && nfound < 4; c++) begin
            @(negedge clk);
            if (rda_gnt && !pa) begin seq[nfound] = "A"; nfound++; end
            else if (rdb_gnt && !pb) begin seq[nfound] = "B"; nfound++; end
            pa = rda_gnt; pb = rdb_gnt;
        end
        chk("alt_count", 128'(nfound), 128'd4);
        for (int i = 0; i < nfound; i++)
            chk($sformatf("alt_order%0d", i), 128'(seq[i]), 128'(alt_exp[i]));
        step_in();
        rda_req = 1'b0; rdb_req = 1'b0;
        auto_drop = 1'b1;
        repeat (6) @(negedge clk);

        // Zero length on B yields exactly one beat
        step_in();
        rdb_addr = 16'h0400; rdb_len = 8'd0; rdb_req = 1'b1;
        wait_for(2, "len0_gnt");
        chk("len0_ptr", 128'(mem_readPtr), 128'h0400);
        @(negedge clk);
        chk("len0_gnt_one", 128'(rdb_gnt), 128'd0);
        chk("len0_beat", 128'({rd_valid_b, rd_last}), 128'b11);
        chk("len0_data", rd_data, pat(16'h0400));

        // Address wrap
        step_in();
        rda_addr = 16'hFFFE; rda_len = 8'd3; rda_req = 1'b1;
        wait_for(1, "wrap_gnt");
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("wrap_ptr%0d", i), 128'(mem_readPtr), 128'(wrap_exp[i]));
        end
        repeat (3) @(negedge clk);

        // Reset during the second issue cycle of a long burst
        step_in();
        rda_addr = 16'h0500; rda_len = 8'd8; rda_req = 1'b1;
        wait_for(1, "abort_gnt");
        step_in();
        reset = 1'b1;
        step_in();
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        @(negedge clk);
        chk("abort_quiet", 128'({rda_gnt, rd_valid_a, rd_last}), 128'd0);
        step_in();
        rda_addr = 16'h0600; rda_len = 8'd2; rda_req = 1'b1;
        wait_for(1, "post_reset_gnt");
        chk("post_reset_ptr0", 128'(mem_readPtr), 128'h0600);
        @(negedge clk);
        chk("post_reset_ptr1", 128'(mem_readPtr), 128'h0601);
        chk("post_reset_beat0", rd_data, pat(16'h0600));
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitration and sequencing controller in front of the 16-bit-addressed, 8-bit-write, 128-bit-read `memory` block in the sparse-matrix multiply datapath. Shares the single memory port between one writer (CSR loader) and two burst readers: A is the matrix value/column fetch, B is the dense vector fetch. It owns `wen`, `writePtr`, `readPtr` and `inData`. It returns read data with per-beat valid and last flags.

## Interface
Parameters
- `MAX_LEN`, 255: largest legal burst length; `rdX_len` is 8 bits wide.

Ports
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_req`  in  1  write request; held until `wr_ack`.
- `wr_addr`  in  16  write address.
- `wr_data`  in  8  write byte.
- `wr_ack`  out  1  one-cycle pulse; the write is issued this cycle.
- `rda_req`, `rdb_req`  in  1  read-burst requests; held until grant.
- `rda_addr`, `rdb_addr`  in  16  burst base address.
- `rda_len`, `rdb_len`  in  8  burst length in words; 0 is treated as 1.
- `rda_gnt`, `rdb_gnt`  out  1  high for every issue cycle of that requester's burst.
- `rd_valid_a`, `rd_valid_b`  out  1  read beat valid.
- `rd_last`  out  1  final beat of the current burst; qualified by a valid.
- `rd_data`  out  128  read beat data, shared by both readers.
- `mem_wen`  out  1  to memory `wen`.
- `mem_writePtr`  out  16  to memory `writePtr`.
- `mem_readPtr`  out  16  to memory `readPtr`.
- `mem_inData`  out  8  to memory `inData`.
- `mem_outData`  in  128  from memory `outData`; registered inside the memory with 1-cycle latency.

## Operation
- States: IDLE, WRITE, BURST_A, BURST_B.
- IDLE
  - Samples requests at the clock edge.
  - Priority: `wr_req` first, then round-robin between A and B using `last_rd`.
  - If A and B both request, the one that was not `last_rd` wins.
  - With no requests, it stays in IDLE.
- WRITE (one cycle)
  - Drives `mem_wen`=1, `mem_writePtr`=`wr_addr`, `mem_inData`=`wr_data`, `wr_ack`=1.
  - Then goes to IDLE.
- Burst entry from IDLE
  - Latches base address into `base`, effective length into `len` (max(len,1)), and `cnt`=0.
  - Sets `last_rd` to the winner.
- BURST_X
  - Each cycle: `mem_readPtr`=`base`+`cnt` (16-bit modulo, wraps 0xFFFF to 0x0000), `rdx_gnt`=1, `mem_wen`=0.
  - `cnt` increments every cycle.
  - On the cycle with `cnt`==`len`-1, goes to IDLE.
- Return path: a 1-stage valid pipeline.
  - The beat issued in cycle n gives `rd_valid_x`=1 and `rd_data`=`mem_outData` in cycle n+1.
  - `rd_last`=1 on the beat from the final issue.
- Request and address inputs are ignored while a burst or write is in progress; dropping a request mid-burst does not shorten the burst.
- Writes never preempt a burst; a pending `wr_req` wins at the next IDLE.
- `mem_writePtr`/`mem_inData` hold their last values when not writing; `mem_readPtr` holds its last value outside bursts.

## Timing
- Reset: state=IDLE, `last_rd`=B (A wins the first tie), `cnt`=0. All outputs are 0, including `mem_*`, `rd_data`, valids, grants and acks.
- Reset mid-burst aborts the burst. No further grants or valids appear; a pending return beat is discarded.
- Every transaction costs one IDLE cycle before it. Write: request seen at edge k, `wr_ack` in cycle k, memory commits at edge k+1.
- Burst of L: grant cycles k..k+L-1, valid beats k+1..k+L, `rd_last` in cycle k+L.
- Back-to-back bursts are separated by exactly one IDLE cycle. The last beat of a burst overlaps that IDLE cycle.
- At most one of `rd_valid_a`/`rd_valid_b` is high in any cycle.

## Test plan
- Reset, then write only:
  - Stimulus: `wr_req` with addr 0x0010, data 0xA5.
  - Required: `wr_ack` for exactly 1 cycle; `mem_wen`=1, `mem_writePtr`=0x0010, `mem_inData`=0xA5 in that same cycle; all outputs 0 before the request.
- Single burst:
  - Stimulus: A with addr 0x0100, len 4.
  - Required: `mem_readPtr` 0x0100..0x0103 on consecutive cycles; `rd_valid_a` 4 beats, each 1 cycle after its address; `rd_last` on the 4th beat; `rda_gnt` 4 cycles.
- Contention:
  - Stimulus: `wr_req`, `rda_req` and `rdb_req` asserted together, all held.
  - Required: grant order is write, A, B; with A and B re-requesting, the order alternates B, A, B…; one IDLE cycle between each transaction.
- Edges of the length and address range:
  - `rdb_len`=0 gives exactly 1 beat with `rd_last`.
  - Base 0xFFFE with len 3 reads 0xFFFE, 0xFFFF, 0x0000.
- Reset asserted in the 2nd cycle of a len-8 burst:
  - Next cycle: state IDLE, no `rd_valid_a` or `rd_last`, all outputs 0.
  - A new request after reset is served normally.
